// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared sequencer types and defaults.
// Contents: pipe_state_e FSM encoding, TIMEOUT_CYC_DEF memory timeout default,
// stage_ctrl_t per-register {wren, clear} pair plus its common settings.
package pipe_stall_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, MEM_WAIT, DIV_BUSY} pipe_state_e;
   localparam int TIMEOUT_CYC_DEF = 64;
   typedef struct packed {
      logic wren;
      logic clear;
   } stage_ctrl_t;
   localparam stage_ctrl_t ST_ADV      = '{wren: 1'b1, clear: 1'b0};
   localparam stage_ctrl_t ST_HOLD     = '{wren: 1'b0, clear: 1'b0};
   localparam stage_ctrl_t ST_BUB      = '{wren: 1'b1, clear: 1'b1};
   localparam stage_ctrl_t ST_HOLD_BUB = '{wren: 1'b0, clear: 1'b1};
endpackage

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges branch flush, load-use, data-memory wait and divider busy
// into per-pipeline-register write-enable/clear pairs; runs dmem and divider handshakes.
// Inputs : clk_i, rst_ni (async, active-low), br_flush_i, load_use_i,
//          EXMEM_mem_rden_i/EXMEM_mem_wren_i, dmem_ack_i, IDEX_div_i, div_done_i.
// Outputs: dmem_req_o, div_start_o, bus_err_o, pc/IFID/IDEX/EXMEM/MEMWB _wren_o,
//          IFID/IDEX/EXMEM/MEMWB _clear_o, stall_cnt_o (only with PIPE_STALL_PERF_EN).
// Config : define PIPE_STALL_PERF_EN to add the 32-bit stalled-cycle counter.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        br_flush_i,
   input  logic        load_use_i,
   input  logic        EXMEM_mem_rden_i,
   input  logic        EXMEM_mem_wren_i,
   input  logic        dmem_ack_i,
   input  logic        IDEX_div_i,
   input  logic        div_done_i,
   output logic        dmem_req_o,
   output logic        div_start_o,
   output logic        bus_err_o,
   output logic        pc_wren_o,
   output logic        IFID_wren_o,
   output logic        IDEX_wren_o,
   output logic        EXMEM_wren_o,
   output logic        MEMWB_wren_o,
   output logic        IFID_clear_o,
   output logic        IDEX_clear_o,
   output logic        EXMEM_clear_o,
   output logic        MEMWB_clear_o
`ifdef PIPE_STALL_PERF_EN
   ,
   output logic [31:0] stall_cnt_o
`endif
);
   pipe_state_e state_q, state_d;
   logic [7:0]  tmo_q, tmo_d;
   logic        div_pend_q, div_pend_d, done_q, done_d;
   logic        pc_we, mem_pend, mem_stall, tmo_hit, div_act, div_fin;
   stage_ctrl_t ifid, idex, exmem, memwb;
   always_comb begin
      mem_pend    = EXMEM_mem_rden_i | EXMEM_mem_wren_i;
      tmo_hit     = tmo_q == 8'(TIMEOUT_CYC);
      // a memory freeze taken while the divider runs parks in MEM_WAIT with div_pend set
      div_act     = state_q == DIV_BUSY || (state_q == MEM_WAIT && div_pend_q);
      div_fin     = div_done_i | done_q;
      // the timeout cycle counts as the ack, so it ends the memory freeze
      mem_stall   = state_q == MEM_WAIT ? !dmem_ack_i && !tmo_hit : mem_pend && !dmem_ack_i;
      dmem_req_o  = mem_pend | (state_q == MEM_WAIT);
      bus_err_o   = state_q == MEM_WAIT && !dmem_ack_i && tmo_hit;
      div_start_o = 1'b0;
      pc_we       = 1'b1;
      ifid        = ST_ADV;
      idex        = ST_ADV;
      exmem       = ST_ADV;
      memwb       = ST_ADV;
      state_d     = IDLE;
      tmo_d       = '0;
      div_pend_d  = 1'b0;
      done_d      = 1'b0;
      if (mem_stall) begin
         pc_we      = 1'b0;
         ifid       = ST_HOLD;
         idex       = ST_HOLD;
         exmem      = ST_HOLD;
         memwb      = ST_HOLD_BUB;
         state_d    = MEM_WAIT;
         tmo_d      = state_q == MEM_WAIT ? tmo_q + 8'd1 : 8'd1;
         div_pend_d = div_act;
         // the divider keeps running; remember a completion until the freeze lifts
         done_d     = div_act & div_fin;
      end else if (div_act) begin
         if (!div_fin) begin
            pc_we   = 1'b0;
            ifid    = ST_HOLD;
            idex    = ST_HOLD;
            exmem   = ST_BUB;
            state_d = DIV_BUSY;
         end
      end else if (IDEX_div_i) begin
         div_start_o = 1'b1;
         pc_we       = 1'b0;
         ifid        = ST_HOLD;
         idex        = ST_HOLD;
         exmem       = ST_BUB;
         state_d     = DIV_BUSY;
      end else if (br_flush_i) begin
         ifid = ST_BUB;
         idex = ST_BUB;
      end else if (load_use_i) begin
         pc_we = 1'b0;
         ifid  = ST_HOLD;
         idex  = ST_BUB;
      end
   end
   assign pc_wren_o     = pc_we;
   assign IFID_wren_o   = ifid.wren;
   assign IDEX_wren_o   = idex.wren;
   assign EXMEM_wren_o  = exmem.wren;
   assign MEMWB_wren_o  = memwb.wren;
   assign IFID_clear_o  = ifid.clear;
   assign IDEX_clear_o  = idex.clear;
   assign EXMEM_clear_o = exmem.clear;
   assign MEMWB_clear_o = memwb.clear;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         div_pend_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         div_pend_q <= div_pend_d;
         done_q     <= done_d;
      end
   end
`ifdef PIPE_STALL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   always_comb stall_cnt_d = pc_we ? stall_cnt_q : stall_cnt_q + 32'd1;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stall_cnt_q <= '0;
      else stall_cnt_q <= stall_cnt_d;
   end
   assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed bench for pipe_stall_ctrl with a per-cycle reference model.
module tb_pipe_stall_ctrl;
   localparam int T = 4;
   logic clk = 0, rst_n = 0, br = 0, lu = 0, rd = 0, wr = 0, ack = 0, div = 0, done = 0;
   logic req, start, err, pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_c, idex_c, exmem_c, memwb_c;
`ifdef PIPE_STALL_PERF_EN
   logic [31:0] scnt;
`endif
   int npass = 0, ntot = 0;
   int n_start = 0, n_err = 0, n_xclr = 0, n_frz = 0;
   always #5 clk = ~clk;

   pipe_stall_ctrl #(.TIMEOUT_CYC(T)) dut (
      .clk_i(clk), .rst_ni(rst_n), .br_flush_i(br), .load_use_i(lu),
      .EXMEM_mem_rden_i(rd), .EXMEM_mem_wren_i(wr), .dmem_ack_i(ack),
      .IDEX_div_i(div), .div_done_i(done),
      .dmem_req_o(req), .div_start_o(start), .bus_err_o(err),
      .pc_wren_o(pc_w), .IFID_wren_o(ifid_w), .IDEX_wren_o(idex_w),
      .EXMEM_wren_o(exmem_w), .MEMWB_wren_o(memwb_w),
      .IFID_clear_o(ifid_c), .IDEX_clear_o(idex_c),
      .EXMEM_clear_o(exmem_c), .MEMWB_clear_o(memwb_c)
`ifdef PIPE_STALL_PERF_EN
      , .stall_cnt_o(scnt)
`endif
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: memory wait length, divider in flight, latched divider completion.
   bit m_memw, m_div, m_done, mreq, stall, errx, fin;
   int m_wait;
   logic [31:0] m_cnt;
   logic [8:0] lo;
   logic [11:0] exp_v, act_v;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_memw = 0; m_div = 0; m_done = 0; m_wait = 0; m_cnt = 0;
      end
      mreq  = rd | wr;
      stall = m_memw ? (!ack && m_wait < T) : (mreq && !ack);
      errx  = m_memw && !ack && m_wait == T;
      fin   = done || m_done;
      // {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_c, idex_c, exmem_c, memwb_c}
      lo = stall ? 9'b0_0000_0001 :
           m_div ? (fin ? 9'b1_1111_0000 : 9'b0_0011_0010) :
           div   ? 9'b0_0011_0010 :
           br    ? 9'b1_1111_1100 :
           lu    ? 9'b0_0111_0100 : 9'b1_1111_0000;
      exp_v = {mreq | m_memw, !stall && !m_div && div, errx, lo};
      act_v = {req, start, err, pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_c, idex_c, exmem_c, memwb_c};
      check("cycle", 32'(act_v), 32'(exp_v));
`ifdef PIPE_STALL_PERF_EN
      check("stall_cnt", scnt, m_cnt);
`endif
      n_start += int'(start);
      n_err   += int'(err);
      n_xclr  += int'(exmem_c);
      n_frz   += int'(act_v[8:0] == 9'b0_0000_0001);
      if (rst_n) begin
         if (!lo[8]) m_cnt++;
         if (stall) begin
            m_wait = m_memw ? m_wait + 1 : 1;
            m_memw = 1;
            if (m_div && done) m_done = 1;
         end else begin
            m_memw = 0;
            m_wait = 0;
            if (m_div) begin
               if (fin) begin m_div = 0; m_done = 0; end
            end else if (div) m_div = 1;
         end
      end
   end

   task automatic apply(logic r, logic w, logic a, logic d, logic dn, logic b, logic l);
      @(posedge clk); #2;
      rd = r; wr = w; ack = a; div = d; done = dn; br = b; lu = l;
      @(negedge clk); #1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check("rst_pc_wren", 32'(pc_w), 1);
      check("rst_req", 32'({req, start, err}), 0);
      check("rst_clears", 32'({ifid_c, idex_c, exmem_c, memwb_c}), 0);
`ifdef PIPE_STALL_PERF_EN
      check("rst_stall_cnt", scnt, 0);
`endif
      @(posedge clk); #2 rst_n = 1;
      // zero-wait load
      apply(1, 0, 1, 0, 0, 0, 0);
      check("zw_req", 32'(req), 1);
      check("zw_pc", 32'(pc_w), 1);
      apply(0, 0, 0, 0, 0, 0, 0);
      check("zw_idle_req", 32'(req), 0);
      // store acked after 3 wait cycles
      n_frz = 0;
      repeat (3) apply(0, 1, 0, 0, 0, 0, 0);
      apply(0, 1, 1, 0, 0, 0, 0);
      check("w3_ack_pc", 32'(pc_w), 1);
      check("w3_ack_memwb_c", 32'(memwb_c), 0);
      apply(0, 0, 0, 0, 0, 0, 0);
      check("w3_frz", n_frz, 3);
      // timeout
      n_err = 0;
      repeat (4) apply(1, 0, 0, 0, 0, 0, 0);
      check("to_early", 32'(err), 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      check("to_err", 32'(err), 1);
      check("to_adv", 32'(pc_w), 1);
      apply(0, 0, 0, 0, 0, 0, 0);
      check("to_req", 32'(req), 0);
      check("to_nerr", n_err, 1);
      // divider with a memory stall in the middle
      n_start = 0; n_xclr = 0;
      apply(0, 0, 0, 1, 0, 0, 0);
      check("div_start", 32'(start), 1);
      check("div_pc", 32'(pc_w), 0);
      apply(0, 0, 0, 1, 0, 0, 0);
      apply(1, 0, 0, 1, 0, 0, 0);
      check("div_memfrz_exw", 32'(exmem_w), 0);
      apply(1, 0, 1, 1, 0, 0, 0);
      check("div_ack_start", 32'(start), 0);
      check("div_ack_xclr", 32'(exmem_c), 1);
      apply(0, 0, 0, 1, 0, 0, 0);
      apply(0, 0, 0, 1, 0, 0, 0);
      apply(0, 0, 0, 1, 1, 0, 0);
      check("div_done_pc", 32'(pc_w), 1);
      check("div_done_xclr", 32'(exmem_c), 0);
      check("div_nstart", n_start, 1);
      check("div_nxclr", n_xclr, 5);
      apply(0, 0, 0, 0, 0, 0, 0);
      // divider completion seen during a memory freeze
      apply(0, 0, 0, 1, 0, 0, 0);
      apply(1, 0, 0, 1, 1, 0, 0);
      apply(1, 0, 1, 1, 0, 0, 0);
      check("latch_pc", 32'(pc_w), 1);
      check("latch_start", 32'(start), 0);
      check("latch_xclr", 32'(exmem_c), 0);
      apply(0, 0, 0, 0, 0, 0, 0);
      check("latch_idle_pc", 32'(pc_w), 1);
      // branch flush and load-use
      apply(0, 0, 0, 0, 0, 1, 1);
      check("fl_clr", 32'({ifid_c, idex_c}), 3);
      check("fl_wr", 32'({pc_w, ifid_w}), 3);
      apply(0, 0, 0, 0, 0, 0, 1);
      check("lu_pc", 32'(pc_w), 0);
      check("lu_idex_c", 32'(idex_c), 1);
      apply(1, 0, 0, 0, 0, 1, 0);
      check("fl_frozen", 32'(ifid_c), 0);
      apply(1, 0, 1, 0, 0, 1, 0);
      check("fl_after_ack", 32'(ifid_c), 1);
      apply(0, 0, 0, 0, 0, 0, 0);
      // async reset while in MEM_WAIT
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      rd = 0; rst_n = 0; #1;
      check("arst_mem_req", 32'(req), 0);
      check("arst_mem_pc", 32'(pc_w), 1);
      check("arst_mem_memwb_c", 32'(memwb_c), 0);
      @(negedge clk);
      @(posedge clk); #2 rst_n = 1;
      apply(0, 0, 0, 0, 0, 0, 0);
      check("arst_mem_idle", 32'(req), 0);
      // async reset mid-divide
      apply(0, 0, 0, 1, 0, 0, 0);
      apply(0, 0, 0, 1, 0, 0, 0);
      div = 0; rst_n = 0; #1;
      check("arst_div_pc", 32'(pc_w), 1);
      check("arst_div_xclr", 32'(exmem_c), 0);
      @(negedge clk);
      @(posedge clk); #2 rst_n = 1;
      apply(0, 0, 0, 1, 0, 0, 0);
      check("arst_div_restart", 32'(start), 1);
      apply(0, 0, 0, 1, 1, 0, 0);
      check("arst_div_done", 32'(pc_w), 1);
      apply(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central pipeline sequencer for the 5-stage core. It merges the four stall/flush sources (branch flush, load-use hazard, data-memory wait states, iterative divider busy) into one write-enable/clear pair per pipeline register. It also runs the handshakes with the data memory and the multi-cycle divider. It sits beside the hazard detection unit, consumes that unit's load-use decision, and drives every pipeline register and the PC.

## Interface
- `TIMEOUT_CYC`, default 64: number of MEM_WAIT cycles without ack before a bus error is declared. Legal range 2..255.
- `clk_i` in 1: core clock; all state on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `br_flush_i` in 1: branch/jump resolved taken in EX.
- `load_use_i` in 1: load-use hazard between ID/EX and IF/ID.
- `EXMEM_mem_rden_i`, `EXMEM_mem_wren_i` in 1 each: the instruction in MEM accesses data memory.
- `dmem_ack_i` in 1: data memory completes the access this cycle.
- `IDEX_div_i` in 1: the instruction in EX is a DIV/REM op.
- `div_done_i` in 1: the divider result is valid this cycle.
- `dmem_req_o` out 1: memory access request.
- `div_start_o` out 1: one-cycle divider start pulse.
- `bus_err_o` out 1: one-cycle timeout pulse.
- `pc_wren_o`, `IFID_wren_o`, `IDEX_wren_o`, `EXMEM_wren_o`, `MEMWB_wren_o` out 1 each: register update enables.
- `IFID_clear_o`, `IDEX_clear_o`, `EXMEM_clear_o`, `MEMWB_clear_o` out 1 each: insert a bubble. Clear overrides wren at the register.
- `stall_cnt_o` out 32: stalled-cycle counter. Present only with the configuration macro.

## Operation
- FSM states are IDLE, MEM_WAIT and DIV_BUSY. Priority order: memory wait > divider busy > branch flush > load-use.
- **IDLE.**
  - With a memory access pending: `dmem_req_o`=1.
  - Same-cycle ack means zero wait states: no stall, stay in IDLE.
  - No ack: all wren=0, `MEMWB_clear_o`=1, go to MEM_WAIT.
- **MEM_WAIT.**
  - `dmem_req_o` stays 1 and all wren stay 0 with `MEMWB_clear_o`=1 until ack.
  - On the ack cycle: normal advance, go to IDLE.
  - After `TIMEOUT_CYC` cycles without ack: `bus_err_o`=1 for one cycle, that cycle is treated as ack, go to IDLE.
- **Divider start.** In IDLE with `IDEX_div_i`=1 and no memory stall: `div_start_o`=1, pc/IFID/IDEX wren=0, `EXMEM_clear_o`=1, go to DIV_BUSY.
- **DIV_BUSY.**
  - Same freeze as the divider start, with no further start pulses.
  - On `div_done_i`: all wren=1 and the div result enters EX/MEM, go to IDLE.
  - A memory stall arriving in DIV_BUSY freezes all stages. The divider keeps running. A `div_done_i` seen during that freeze is latched and honored on the first non-frozen cycle.
- **Branch flush.** Honored only when EX advances (no memory or divider stall): `IFID_clear_o`=`IDEX_clear_o`=1, pc/IFID wren=1. A flush seen while frozen is re-presented by the held EX stage and is not latched.
- **Load-use.** Honored only when there is no higher-priority stall: pc/IFID wren=0, `IDEX_clear_o`=1.
- **Normal.** All wren=1, all clears=0.

## Timing
- **Reset values:**
  - `dmem_req_o`=`div_start_o`=`bus_err_o`=0.
  - All wren=1, all clears=0.
  - State IDLE, timeout counter 0, `stall_cnt_o`=0.
- Enables and clears are combinational from state plus inputs, and valid in the same cycle.
- Request, start and error outputs are also combinational.
- Timeout counter: 8-bit. It counts from 1 on the first MEM_WAIT cycle, the error fires when the count equals `TIMEOUT_CYC`, and it resets to 0 on leaving MEM_WAIT.
- Reset mid-operation: immediate return to IDLE. An in-flight divider or memory operation is abandoned; the external units must also be reset.
- `stall_cnt_o` increments on each cycle with `pc_wren_o`=0 and wraps 0xFFFF_FFFF→0.

## Configuration
- `PIPE_STALL_PERF_EN` defined: `stall_cnt_o` port and counter exist.
- Not defined: the port and counter are absent. No other behavioural change.

## Structure
- Shared core package holds:
  - the `pipe_state_e` enum (IDLE/MEM_WAIT/DIV_BUSY);
  - the `TIMEOUT_CYC` default constant;
  - a `stage_ctrl_t` struct {wren, clear}.
- Single module; no sub-module needed. The timeout counter is inline.

## Test plan
- Zero-wait load, ack same cycle → no wren drops, state stays IDLE.
- Load with ack after 3 cycles → 3 cycles of all wren=0 plus `MEMWB_clear_o`=1, then advance.
- No ack with `TIMEOUT_CYC`=4 → `bus_err_o` pulses on the 4th MEM_WAIT cycle, pipeline advances, then IDLE.
- DIV in EX, done after 5 cycles → one `div_start_o` pulse and 5 cycles of `EXMEM_clear_o`=1; a stall during DIV_BUSY produces no second start; advance on done.
- `br_flush_i` and `load_use_i` together with no memory wait → IF/ID and ID/EX cleared, PC written.
- `rst_ni` low in MEM_WAIT and mid-div → outputs at reset values asynchronously, IDLE after release.
